// File: rtl/pc_fetch.sv
// Program counter and single-outstanding instruction-fetch unit for LemonPC.
// One request in flight at a time; the returned instruction is held in a
// one-entry buffer until decode accepts it. A redirect while a request is in
// flight marks that response for killing instead of waiting it out.
module pc_fetch #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned INST_W    = 32,
    parameter logic [63:0] RESET_VEC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_misalign
);

    localparam logic [XLEN-1:0] RST_PC = RESET_VEC[XLEN-1:0];

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        HOLD,
        TRAP,
        HALT
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic              kill, kill_n;
    logic              ld_inst, ld_trap;
    logic [INST_W-1:0] inst_r;
    logic [XLEN-1:0]   inst_pc_r;
    logic              misalign_r;

    assign imem_req_addr = pc;
    assign inst          = inst_r;
    assign inst_pc       = inst_pc_r;
    assign inst_misalign = misalign_r;

    // Control state: FSM state, architectural PC and the stale-response kill flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RST_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            kill  <= kill_n;
        end
    end

    // Next-state logic and handshake gating; redirect outranks every other event.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        kill_n         = kill;
        ld_inst        = 1'b0;
        ld_trap        = 1'b0;
        imem_req_valid = !rst && (state == FETCH) && !redirect_valid && (pc[1:0] == 2'b00);
        inst_valid     = !rst && ((state == HOLD) || (state == TRAP)) && !redirect_valid;

        if (redirect_valid) begin
            pc_n = redirect_pc;
            if ((state == WAIT) && !imem_resp_valid) begin
                // Request still in flight: let its response drain, then drop it.
                kill_n = 1'b1;
            end else begin
                kill_n  = 1'b0;
                state_n = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (pc[1:0] != 2'b00) begin
                        ld_trap = 1'b1;
                        state_n = TRAP;
                    end else if (imem_req_ready) begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill) begin
                            kill_n  = 1'b0;
                            state_n = FETCH;
                        end else begin
                            ld_inst = 1'b1;
                            pc_n    = pc + XLEN'(4);
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) state_n = FETCH;
                end
                TRAP: begin
                    if (inst_ready) state_n = HALT;
                end
                HALT: begin
                    state_n = HALT;
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // One-entry instruction buffer presented to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_r     <= '0;
            inst_pc_r  <= '0;
            misalign_r <= 1'b0;
        end else if (ld_inst) begin
            inst_r     <= imem_resp_data;
            inst_pc_r  <= pc;
            misalign_r <= 1'b0;
        end else if (ld_trap) begin
            inst_r     <= '0;
            inst_pc_r  <= pc;
            misalign_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch: one 64-bit instance for the main
// sequence and one 32-bit instance for PC wrap-around.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_misalign;

    logic        r32_valid = 1'b0;
    logic [31:0] r32_pc = '0;
    logic        req32_valid;
    logic        req32_ready = 1'b0;
    logic [31:0] req32_addr;
    logic        resp32_valid = 1'b0;
    logic [31:0] resp32_data = '0;
    logic        inst32_valid;
    logic        inst32_ready = 1'b0;
    logic [31:0] inst32;
    logic [31:0] inst32_pc;
    logic        inst32_misalign;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned hs_cnt = 0;
    int unsigned hs0;

    always #5 clk = ~clk;

    pc_fetch #(.XLEN(64), .INST_W(32), .RESET_VEC(64'h0000_0000_8000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_misalign(inst_misalign)
    );

    pc_fetch #(.XLEN(32), .INST_W(32), .RESET_VEC(64'h0000_0000_8000_0000)) dut32 (
        .clk(clk), .rst(rst),
        .redirect_valid(r32_valid), .redirect_pc(r32_pc),
        .imem_req_valid(req32_valid), .imem_req_ready(req32_ready),
        .imem_req_addr(req32_addr),
        .imem_resp_valid(resp32_valid), .imem_resp_data(resp32_data),
        .inst_valid(inst32_valid), .inst_ready(inst32_ready),
        .inst(inst32), .inst_pc(inst32_pc), .inst_misalign(inst32_misalign)
    );

    // Count decode handshakes on the 64-bit instance.
    always @(posedge clk) begin
        if (inst_valid && inst_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_hs(input logic [63:0] addr);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (imem_req_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("req_seen", 64'(seen), 64'd1);
        check_eq("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic resp(input int unsigned lat, input logic [31:0] data);
        repeat (lat - 1) tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        tick();
        imem_resp_valid = 1'b0;
    endtask

    task automatic check_hold(input logic [31:0] data, input logic [63:0] pc);
        #1;
        check_eq("hold_valid", 64'(inst_valid), 64'd1);
        check_eq("hold_inst", 64'(inst), 64'(data));
        check_eq("hold_pc", inst_pc, pc);
        check_eq("hold_misalign", 64'(inst_misalign), 64'd0);
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check_eq("rst_pc", imem_req_addr, 64'h8000_0000);
        check_eq("rst_inst", 64'(inst), 64'd0);
        rst = 1'b0;

        // Back-to-back fetches, 1-cycle memory
        req_hs(64'h8000_0000); resp(1, 32'h0000_0013); check_hold(32'h0000_0013, 64'h8000_0000); accept();
        req_hs(64'h8000_0004); resp(1, 32'h1234_5678); check_hold(32'h1234_5678, 64'h8000_0004); accept();
        req_hs(64'h8000_0008); resp(1, 32'hA5A5_5A5A); check_hold(32'hA5A5_5A5A, 64'h8000_0008); accept();

        // 4-cycle memory, decode stalls 5 cycles
        req_hs(64'h8000_000C);
        resp(4, 32'h0BAD_CAFE);
        check_hold(32'h0BAD_CAFE, 64'h8000_000C);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", 64'(inst_valid), 64'd1);
            check_eq("stall_inst", 64'(inst), 64'h0BAD_CAFE);
            check_eq("stall_pc", inst_pc, 64'h8000_000C);
            check_eq("stall_noreq", 64'(imem_req_valid), 64'd0);
        end
        accept();

        // Redirect in WAIT, stale response two cycles later
        req_hs(64'h8000_0010);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("kill_noreq", 64'(imem_req_valid), 64'd0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        #1;
        check_eq("kill_inst_valid", 64'(inst_valid), 64'd0);
        req_hs(64'h8000_1000); resp(1, 32'h0000_1111); check_hold(32'h0000_1111, 64'h8000_1000); accept();

        // Redirect together with the response
        req_hs(64'h8000_1004);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_F00D;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_2000;
        tick();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        #1;
        check_eq("rdresp_inst_valid", 64'(inst_valid), 64'd0);

        // Redirect together with inst_ready in HOLD
        req_hs(64'h8000_2000); resp(1, 32'h0000_2222); check_hold(32'h0000_2222, 64'h8000_2000);
        hs0 = hs_cnt;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        #1;
        check_eq("rdhold_gated", 64'(inst_valid), 64'd0);
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_eq("rdhold_no_hs", 64'(hs_cnt), 64'(hs0));
        check_eq("rdhold_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rdhold_addr", imem_req_addr, 64'h8000_3000);

        // Misaligned redirect target -> trap -> halt -> resume
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0006;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("mis_noreq", 64'(imem_req_valid), 64'd0);
        tick();
        check_eq("trap_valid", 64'(inst_valid), 64'd1);
        check_eq("trap_misalign", 64'(inst_misalign), 64'd1);
        check_eq("trap_pc", inst_pc, 64'h8000_0006);
        check_eq("trap_inst", 64'(inst), 64'd0);
        check_eq("trap_noreq", 64'(imem_req_valid), 64'd0);
        accept();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("halt_noreq", 64'(imem_req_valid), 64'd0);
            check_eq("halt_inst_valid", 64'(inst_valid), 64'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        req_hs(64'h8000_0100); resp(1, 32'h0000_0100); check_hold(32'h0000_0100, 64'h8000_0100); accept();

        // Reset while waiting; late response ignored
        req_hs(64'h8000_0104);
        rst = 1'b1;
        #1;
        check_eq("rstw_noreq", 64'(imem_req_valid), 64'd0);
        tick();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAAD_F00D;
        #1;
        check_eq("rstw_addr", imem_req_addr, 64'h8000_0000);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        check_eq("late_inst_valid", 64'(inst_valid), 64'd0);
        req_hs(64'h8000_0000); resp(1, 32'h7777_0000); check_hold(32'h7777_0000, 64'h8000_0000); accept();

        // XLEN=32 wrap-around
        r32_valid = 1'b1;
        r32_pc    = 32'hFFFF_FFFC;
        tick();
        r32_valid = 1'b0;
        #1;
        check_eq("w32_req_valid", 64'(req32_valid), 64'd1);
        check_eq("w32_addr0", 64'(req32_addr), 64'hFFFF_FFFC);
        req32_ready = 1'b1;
        tick();
        req32_ready  = 1'b0;
        resp32_valid = 1'b1;
        resp32_data  = 32'h1111_2222;
        tick();
        resp32_valid = 1'b0;
        #1;
        check_eq("w32_valid0", 64'(inst32_valid), 64'd1);
        check_eq("w32_pc0", 64'(inst32_pc), 64'hFFFF_FFFC);
        inst32_ready = 1'b1;
        tick();
        inst32_ready = 1'b0;
        #1;
        check_eq("w32_addr1", 64'(req32_addr), 64'h0);
        req32_ready = 1'b1;
        tick();
        req32_ready  = 1'b0;
        resp32_valid = 1'b1;
        resp32_data  = 32'h3333_4444;
        tick();
        resp32_valid = 1'b0;
        #1;
        check_eq("w32_pc1", 64'(inst32_pc), 64'h0);
        check_eq("w32_inst1", 64'(inst32), 64'h3333_4444);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Parametrised program-counter and instruction-fetch unit for the LemonPC core.
- Holds the architectural PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Captures the returned instruction in a one-entry buffer and hands it to decode with backpressure.
- Supports redirect (branch/jump/trap target) with stale-response kill, and misaligned-target trapping; wrap-around is modulo 2^XLEN.

Parameters:
XLEN, 64, PC and address width in bits
INST_W, 32, instruction width in bits
RESET_VEC, 64'h0000_0000_8000_0000, PC value loaded on reset (truncated to XLEN)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
redirect_valid  input  1  load new PC this cycle
redirect_pc  input  XLEN  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address
imem_resp_valid  input  1  response valid (single-cycle pulse, always accepted)
imem_resp_data  input  INST_W  fetched instruction
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst  output  INST_W  instruction (0 when inst_misalign=1)
inst_pc  output  XLEN  PC of inst
inst_misalign  output  1  instruction-address-misaligned trap marker

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - State FETCH, pc=RESET_VEC, kill=0, inst/inst_pc/inst_misalign=0.
  - inst_valid=0 and imem_req_valid=0 while rst=1.
  - rst=1 mid-operation aborts everything.
  - Responses arriving in any state other than WAIT are ignored.
- States: FETCH, WAIT, HOLD, TRAP, HALT.
- Combinational gating:
  - imem_req_valid = (state==FETCH) && !redirect_valid && pc[1:0]==0.
  - inst_valid = (state==HOLD || state==TRAP) && !redirect_valid.
  - imem_req_addr = pc.
- Priority: redirect_valid beats every other event in the same cycle.
  - pc <= redirect_pc.
  - Any held or trap instruction is discarded, and its inst_ready in that cycle is not a handshake.
- FETCH:
  - If pc[1:0]!=0: no request; next state TRAP with inst_pc=pc, inst=0, inst_misalign=1.
  - Else on req handshake: next state WAIT.
  - Redirect: stay FETCH with new pc.
- WAIT:
  - On imem_resp_valid with kill=0: inst<=imem_resp_data, inst_pc<=pc, inst_misalign<=0, pc<=pc+4 (mod 2^XLEN); next state HOLD.
  - On imem_resp_valid with kill=1: drop data, kill<=0; next state FETCH.
  - Redirect without response: kill<=1, stay WAIT.
  - Redirect with response in the same cycle: drop data, kill<=0, next state FETCH.
- HOLD: on inst_valid && inst_ready, next state FETCH. Redirect: next state FETCH.
- TRAP: on handshake, next state HALT (no further fetches). Redirect: next state FETCH.
- HALT: idle, outputs invalid; only a redirect leaves it (to FETCH).
- Latency and throughput:
  - Request to inst_valid is the memory latency plus 1 cycle (response registered).
  - At most one request outstanding; throughput is at most one instruction per 3 cycles with a 1-cycle memory.
- Held outputs inst, inst_pc and inst_misalign are stable while inst_valid=1 and not accepted.
- Misaligned redirect target: accepted into pc; the trap is raised when FETCH sees it, after any kill drain.

Test Plan:
- Reset, then 1-cycle memory always ready, decode always ready -> requests at 0x80000000, 0x80000004, 0x80000008; inst_pc matches each; data passes through unchanged.
- Memory latency 4 cycles, inst_ready low for 5 cycles while in HOLD -> inst/inst_pc held constant, no new imem request until handshake, then the next address is +4.
- Redirect to 0x80001000 while in WAIT, stale response 2 cycles later -> stale data never appears on inst; next request addr=0x80001000.
- Redirect in the same cycle as imem_resp_valid, and separately in the same cycle as inst_ready in HOLD -> response/held inst dropped, no handshake counted, next request at redirect target.
- Redirect to 0x80000006 -> no imem request; inst_valid=1, inst_misalign=1, inst_pc=0x80000006, inst=0; after accept, HALT with no requests until a redirect to 0x80000100 resumes fetch there.
- XLEN=32, pc forced via redirect to 0xFFFFFFFC -> the instruction after it has inst_pc=0x00000000. rst asserted in WAIT -> next fetch at RESET_VEC, and a late response is ignored.
